// File: rtl/riscv_mem_arbiter.sv
// Two-client (icache/dcache) arbiter onto the single external memory port, with write-burst grant lock.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise dcache wins every tie.
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 28
`endif
`ifndef MEM_DATA_BITS
`define MEM_DATA_BITS 64
`endif
`ifndef MEM_TAG_BITS
`define MEM_TAG_BITS 5
`endif

module riscv_mem_arbiter #(
  parameter int ADDR_BITS  = `MEM_ADDR_BITS,
  parameter int DATA_BITS  = `MEM_DATA_BITS,
  parameter int TAG_BITS   = `MEM_TAG_BITS,
  parameter int DATA_BEATS = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ic_req_valid,
  output logic                   ic_req_ready,
  input  logic                   ic_req_rw,
  input  logic [ADDR_BITS-1:0]   ic_req_addr,
  input  logic [TAG_BITS-2:0]    ic_req_tag,
  input  logic                   ic_req_data_valid,
  output logic                   ic_req_data_ready,
  input  logic [DATA_BITS-1:0]   ic_req_data_bits,
  input  logic [DATA_BITS/8-1:0] ic_req_data_mask,
  output logic                   ic_resp_valid,
  output logic [TAG_BITS-2:0]    ic_resp_tag,
  output logic [DATA_BITS-1:0]   ic_resp_data,
  input  logic                   dc_req_valid,
  output logic                   dc_req_ready,
  input  logic                   dc_req_rw,
  input  logic [ADDR_BITS-1:0]   dc_req_addr,
  input  logic [TAG_BITS-2:0]    dc_req_tag,
  input  logic                   dc_req_data_valid,
  output logic                   dc_req_data_ready,
  input  logic [DATA_BITS-1:0]   dc_req_data_bits,
  input  logic [DATA_BITS/8-1:0] dc_req_data_mask,
  output logic                   dc_resp_valid,
  output logic [TAG_BITS-2:0]    dc_resp_tag,
  output logic [DATA_BITS-1:0]   dc_resp_data,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic                   mem_req_rw,
  output logic [ADDR_BITS-1:0]   mem_req_addr,
  output logic [TAG_BITS-1:0]    mem_req_tag,
  output logic                   mem_req_data_valid,
  input  logic                   mem_req_data_ready,
  output logic [DATA_BITS-1:0]   mem_req_data_bits,
  output logic [DATA_BITS/8-1:0] mem_req_data_mask,
  input  logic                   mem_resp_valid,
  input  logic [TAG_BITS-1:0]    mem_resp_tag,
  input  logic [DATA_BITS-1:0]   mem_resp_data
);
  localparam int CNT_BITS = (DATA_BEATS > 1) ? $clog2(DATA_BEATS) : 1;
  localparam logic GNT_IC = 1'b0;
  localparam logic GNT_DC = 1'b1;

  typedef enum logic {IDLE, WDATA} state_t;

  state_t              state_reg;
  logic [CNT_BITS-1:0] beat_cnt_reg;
  logic                last_grant_reg;
  logic                lock_grant_reg;
  logic                hold_valid_reg;
  logic                hold_grant_reg;

  logic grant, sel, idle, wdata, hold_ok, req_fire, beat_fire;

  assign idle    = (state_reg == IDLE);
  assign wdata   = (state_reg == WDATA);
  // A stalled request pins its grant until it fires, even if the other client arrives meanwhile.
  assign hold_ok = hold_valid_reg && (hold_grant_reg ? dc_req_valid : ic_req_valid);

  always_comb begin
    grant = GNT_IC;
    if (hold_ok)
      grant = hold_grant_reg;
    else if (ic_req_valid && dc_req_valid)
`ifdef MEM_ARB_RR_EN
      grant = ~last_grant_reg;
`else
      grant = GNT_DC;
`endif
    else if (dc_req_valid)
      grant = GNT_DC;
  end

`ifndef MEM_ARB_RR_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant_reg;
`endif

  assign sel = idle ? grant : lock_grant_reg;

  assign mem_req_valid = idle && (ic_req_valid || dc_req_valid) && !reset;
  assign ic_req_ready  = idle && (grant == GNT_IC) && mem_req_ready && !reset;
  assign dc_req_ready  = idle && (grant == GNT_DC) && mem_req_ready && !reset;
  assign mem_req_rw    = sel ? dc_req_rw   : ic_req_rw;
  assign mem_req_addr  = sel ? dc_req_addr : ic_req_addr;
  assign mem_req_tag   = {sel, (sel ? dc_req_tag : ic_req_tag)};

  assign mem_req_data_valid = wdata && !reset &&
                              (lock_grant_reg ? dc_req_data_valid : ic_req_data_valid);
  assign ic_req_data_ready  = wdata && (lock_grant_reg == GNT_IC) && mem_req_data_ready && !reset;
  assign dc_req_data_ready  = wdata && (lock_grant_reg == GNT_DC) && mem_req_data_ready && !reset;
  assign mem_req_data_bits  = sel ? dc_req_data_bits : ic_req_data_bits;
  assign mem_req_data_mask  = sel ? dc_req_data_mask : ic_req_data_mask;

  assign req_fire  = mem_req_valid && mem_req_ready;
  assign beat_fire = mem_req_data_valid && mem_req_data_ready;

  // Responses are steered purely by the tag MSB, whatever the request side is doing.
  logic [1:0] resp_hit;
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_resp
      assign resp_hit[gi] = mem_resp_valid && !reset && (mem_resp_tag[TAG_BITS-1] == (gi == 1));
    end
  endgenerate

  assign ic_resp_valid = resp_hit[0];
  assign dc_resp_valid = resp_hit[1];
  assign ic_resp_tag   = mem_resp_tag[TAG_BITS-2:0];
  assign dc_resp_tag   = mem_resp_tag[TAG_BITS-2:0];
  assign ic_resp_data  = mem_resp_data;
  assign dc_resp_data  = mem_resp_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      beat_cnt_reg   <= '0;
      last_grant_reg <= GNT_IC;
      lock_grant_reg <= GNT_IC;
      hold_valid_reg <= 1'b0;
      hold_grant_reg <= GNT_IC;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_fire) begin
            last_grant_reg <= grant;
            hold_valid_reg <= 1'b0;
            if (mem_req_rw) begin
              state_reg      <= WDATA;
              lock_grant_reg <= grant;
              beat_cnt_reg   <= '0;
            end
          end else if (mem_req_valid) begin
            hold_valid_reg <= 1'b1;
            hold_grant_reg <= grant;
          end else begin
            hold_valid_reg <= 1'b0;
          end
        end
        WDATA: begin
          if (beat_fire) begin
            if (beat_cnt_reg == CNT_BITS'(DATA_BEATS - 1)) begin
              state_reg    <= IDLE;
              beat_cnt_reg <= '0;
            end else begin
              beat_cnt_reg <= beat_cnt_reg + 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Scoreboard bench for riscv_mem_arbiter: stimulus queues expected memory-side requests, beats and
// client responses; a negedge monitor pops and compares whenever the DUT presents one.
module tb_riscv_mem_arbiter;
  localparam int AB = 28;
  localparam int DB = 64;
  localparam int TB = 5;

  logic clk, reset;
  logic ic_req_valid, ic_req_ready, ic_req_rw, ic_req_data_valid, ic_req_data_ready, ic_resp_valid;
  logic dc_req_valid, dc_req_ready, dc_req_rw, dc_req_data_valid, dc_req_data_ready, dc_resp_valid;
  logic [AB-1:0] ic_req_addr, dc_req_addr, mem_req_addr;
  logic [TB-2:0] ic_req_tag, dc_req_tag, ic_resp_tag, dc_resp_tag;
  logic [DB-1:0] ic_req_data_bits, dc_req_data_bits, ic_resp_data, dc_resp_data;
  logic [DB-1:0] mem_req_data_bits, mem_resp_data;
  logic [DB/8-1:0] ic_req_data_mask, dc_req_data_mask, mem_req_data_mask;
  logic mem_req_valid, mem_req_ready, mem_req_rw, mem_req_data_valid, mem_req_data_ready;
  logic mem_resp_valid;
  logic [TB-1:0] mem_req_tag, mem_resp_tag;

  riscv_mem_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .TAG_BITS(TB), .DATA_BEATS(4)) dut (
    .clk(clk), .reset(reset),
    .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_rw(ic_req_rw),
    .ic_req_addr(ic_req_addr), .ic_req_tag(ic_req_tag),
    .ic_req_data_valid(ic_req_data_valid), .ic_req_data_ready(ic_req_data_ready),
    .ic_req_data_bits(ic_req_data_bits), .ic_req_data_mask(ic_req_data_mask),
    .ic_resp_valid(ic_resp_valid), .ic_resp_tag(ic_resp_tag), .ic_resp_data(ic_resp_data),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_rw(dc_req_rw),
    .dc_req_addr(dc_req_addr), .dc_req_tag(dc_req_tag),
    .dc_req_data_valid(dc_req_data_valid), .dc_req_data_ready(dc_req_data_ready),
    .dc_req_data_bits(dc_req_data_bits), .dc_req_data_mask(dc_req_data_mask),
    .dc_resp_valid(dc_resp_valid), .dc_resp_tag(dc_resp_tag), .dc_resp_data(dc_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
    .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_tag(mem_resp_tag), .mem_resp_data(mem_resp_data)
  );

  typedef struct {logic rw; logic [AB-1:0] addr; logic [TB-1:0] tag;} req_t;
  typedef struct {logic dc; logic [DB-1:0] bits; logic [DB/8-1:0] mask;} beat_t;
  typedef struct {logic dc; logic [TB-2:0] tag; logic [DB-1:0] data;} resp_t;

  req_t  exp_req_q[$];
  beat_t exp_beat_q[$];
  resp_t exp_resp_q[$];
  int vectors = 0;
  int miscompares = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: DUT presented a transaction with nothing expected", name);
  endtask

  // Monitor: compares every handshake/response the DUT presents against the scoreboard.
  initial begin
    req_t r; beat_t b; resp_t p;
    forever begin
      @(negedge clk);
      if (mem_req_valid && mem_req_ready) begin
        if (exp_req_q.size() == 0) unexpected("req_extra");
        else begin
          r = exp_req_q.pop_front();
          $display("req  rw=%0d addr=%0h tag=%0h", mem_req_rw, mem_req_addr, mem_req_tag);
          check("req_tag", 64'(mem_req_tag), 64'(r.tag));
          check("req_addr", 64'(mem_req_addr), 64'(r.addr));
          check("req_rw", 64'(mem_req_rw), 64'(r.rw));
          check("req_ready_route", 64'({ic_req_ready, dc_req_ready}), r.tag[TB-1] ? 64'h1 : 64'h2);
        end
      end
      if (mem_req_data_valid && mem_req_data_ready) begin
        if (exp_beat_q.size() == 0) unexpected("beat_extra");
        else begin
          b = exp_beat_q.pop_front();
          $display("beat data=%0h mask=%0h", mem_req_data_bits, mem_req_data_mask);
          check("beat_bits", mem_req_data_bits, b.bits);
          check("beat_mask", 64'(mem_req_data_mask), 64'(b.mask));
          check("beat_ready_route", 64'({ic_req_data_ready, dc_req_data_ready}), b.dc ? 64'h1 : 64'h2);
        end
      end
      if (ic_resp_valid || dc_resp_valid) begin
        if (exp_resp_q.size() == 0) unexpected("resp_extra");
        else begin
          p = exp_resp_q.pop_front();
          $display("resp ic=%0d dc=%0d tag=%0h", ic_resp_valid, dc_resp_valid, mem_resp_tag);
          check("resp_route", 64'({ic_resp_valid, dc_resp_valid}), p.dc ? 64'h1 : 64'h2);
          check("resp_tag", 64'(p.dc ? dc_resp_tag : ic_resp_tag), 64'(p.tag));
          check("resp_data", p.dc ? dc_resp_data : ic_resp_data, p.data);
        end
      end
    end
  end

  task automatic do_req(input bit dc, input bit rw, input logic [AB-1:0] addr,
                        input logic [TB-2:0] tag, output int waited);
    req_t e;
    if (dc) begin
      dc_req_valid = 1'b1; dc_req_rw = rw; dc_req_addr = addr; dc_req_tag = tag;
    end else begin
      ic_req_valid = 1'b1; ic_req_rw = rw; ic_req_addr = addr; ic_req_tag = tag;
    end
    e.rw = rw; e.addr = addr; e.tag = {dc, tag};
    exp_req_q.push_back(e);
    waited = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (dc ? dc_req_ready : ic_req_ready) begin
        waited = c;
        break;
      end
    end
    if (waited < 0) begin
      vectors++; miscompares++;
      $display("FAIL req_timeout: no req_ready within 20 cycles, required one");
    end
    @(posedge clk); #1;
    if (dc) dc_req_valid = 1'b0; else ic_req_valid = 1'b0;
  endtask

  task automatic do_beats(input bit dc, input logic [DB-1:0] base, input int n);
    beat_t e;
    bit seen;
    for (int i = 0; i < n; i++) begin
      e.dc = dc; e.bits = base + DB'(i); e.mask = 8'(8'hA5 + i);
      if (dc) begin
        dc_req_data_valid = 1'b1; dc_req_data_bits = e.bits; dc_req_data_mask = e.mask;
      end else begin
        ic_req_data_valid = 1'b1; ic_req_data_bits = e.bits; ic_req_data_mask = e.mask;
      end
      exp_beat_q.push_back(e);
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge clk);
        seen = dc ? dc_req_data_ready : ic_req_data_ready;
      end
      check("wdata_beat_accepted", 64'(seen), 64'h1);
      check("wdata_req_blocked", 64'({mem_req_valid, ic_req_ready, dc_req_ready}), 64'h0);
      @(posedge clk); #1;
    end
    if (dc) dc_req_data_valid = 1'b0; else ic_req_data_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    resp_t p;
    // Reset with every input asserted: all valid/ready outputs must stay low.
    reset = 1'b1;
    ic_req_valid = 1'b1; ic_req_rw = 1'b0; ic_req_addr = '0; ic_req_tag = '0;
    dc_req_valid = 1'b1; dc_req_rw = 1'b0; dc_req_addr = '0; dc_req_tag = '0;
    ic_req_data_valid = 1'b1; ic_req_data_bits = '0; ic_req_data_mask = '0;
    dc_req_data_valid = 1'b1; dc_req_data_bits = '0; dc_req_data_mask = '0;
    mem_req_ready = 1'b1; mem_req_data_ready = 1'b1;
    mem_resp_valid = 1'b1; mem_resp_tag = '0; mem_resp_data = '0;
    @(negedge clk);
    check("rst_mem_valids", 64'({mem_req_valid, mem_req_data_valid}), 64'h0);
    check("rst_req_readys", 64'({ic_req_ready, dc_req_ready, ic_req_data_ready, dc_req_data_ready}), 64'h0);
    check("rst_resp_valids", 64'({ic_resp_valid, dc_resp_valid}), 64'h0);
    @(posedge clk); #1;
    ic_req_valid = 0; dc_req_valid = 0; ic_req_data_valid = 0; dc_req_data_valid = 0;
    mem_resp_valid = 0;
    reset = 1'b0;

    // 1: reset in the middle of a dcache write burst, then a full burst from beat 0.
    do_req(1, 1, 28'h40, 4'h2, w);
    do_beats(1, 64'h1000, 2);
    dc_req_data_valid = 1'b1; dc_req_data_bits = 64'h1002; reset = 1'b1;
    @(negedge clk);
    check("t1_rst_readys", 64'({ic_req_ready, dc_req_ready, dc_req_data_ready, mem_req_data_valid}), 64'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("t1_idle_no_early_data", 64'({mem_req_data_valid, dc_req_data_ready}), 64'h0);
    @(posedge clk); #1;
    dc_req_data_valid = 1'b0;
    do_req(1, 1, 28'h40, 4'h2, w);
    check("t1_restart_latency", 64'(w), 64'h0);
    do_beats(1, 64'h2000, 4);

    // 2: lone icache read passes straight through; its response routes to icache.
    do_req(0, 0, 28'h100, 4'h3, w);
    check("t2_zero_latency", 64'(w), 64'h0);
    mem_resp_valid = 1'b1; mem_resp_tag = 5'h03; mem_resp_data = 64'hDEAD_BEEF_0000_0103;
    p.dc = 1'b0; p.tag = 4'h3; p.data = 64'hDEAD_BEEF_0000_0103;
    exp_resp_q.push_back(p);
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;

    // 3: dcache write burst while icache read waits; icache granted right after beat 4.
    ic_req_valid = 1'b1; ic_req_rw = 1'b0; ic_req_addr = 28'h200; ic_req_tag = 4'h1;
    do_req(1, 1, 28'h40, 4'h5, w);
    do_beats(1, 64'h3000, 4);
    do_req(0, 0, 28'h200, 4'h1, w);
    check("t3_ic_granted_after_burst", 64'(w), 64'h0);

    // 4: both read every cycle for 4 cycles (last grant was icache).
    ic_req_valid = 1'b1; ic_req_rw = 1'b0; ic_req_addr = 28'h300; ic_req_tag = 4'h4;
    dc_req_valid = 1'b1; dc_req_rw = 1'b0; dc_req_addr = 28'h400; dc_req_tag = 4'h6;
`ifdef MEM_ARB_RR_EN
    exp_req_q.push_back('{1'b0, 28'h400, 5'h16});
    exp_req_q.push_back('{1'b0, 28'h300, 5'h04});
    exp_req_q.push_back('{1'b0, 28'h400, 5'h16});
    exp_req_q.push_back('{1'b0, 28'h300, 5'h04});
`else
    for (int i = 0; i < 4; i++) exp_req_q.push_back('{1'b0, 28'h400, 5'h16});
`endif
    repeat (4) @(posedge clk);
    #1;
    ic_req_valid = 1'b0; dc_req_valid = 1'b0;

    // 5: stalled icache request keeps its grant when dcache joins; both drain afterwards.
    mem_req_ready = 1'b0;
    ic_req_valid = 1'b1; ic_req_addr = 28'h500; ic_req_tag = 4'h7;
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin
        dc_req_valid = 1'b1; dc_req_rw = 1'b0; dc_req_addr = 28'h600; dc_req_tag = 4'h1;
      end
      @(negedge clk);
      check("t5_stall_tag", 64'(mem_req_tag), 64'h07);
      check("t5_stall_addr", 64'(mem_req_addr), 64'h500);
      @(posedge clk); #1;
    end
    mem_req_ready = 1'b1;
    exp_req_q.push_back('{1'b0, 28'h500, 5'h07});
    exp_req_q.push_back('{1'b0, 28'h600, 5'h11});
    @(posedge clk); #1;
    ic_req_valid = 1'b0;
    @(posedge clk); #1;
    dc_req_valid = 1'b0;

    // 6: dcache read response lands during an icache write burst.
    do_req(0, 1, 28'h700, 4'h2, w);
    fork
      do_beats(0, 64'h6000, 4);
      begin
        @(posedge clk); #1;
        mem_resp_valid = 1'b1; mem_resp_tag = 5'h15; mem_resp_data = 64'hCAFE_0000_0000_0015;
        p.dc = 1'b1; p.tag = 4'h5; p.data = 64'hCAFE_0000_0000_0015;
        exp_resp_q.push_back(p);
        @(posedge clk); #1;
        mem_resp_valid = 1'b0;
      end
    join
    do_req(1, 0, 28'h800, 4'h3, w);
    check("t6_idle_after_4_beats", 64'(w), 64'h0);

    repeat (3) @(posedge clk);
    #1;
    check("req_q_drained", 64'(exp_req_q.size()), 64'h0);
    check("beat_q_drained", 64'(exp_beat_q.size()), 64'h0);
    check("resp_q_drained", 64'(exp_resp_q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
